// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes, FSM states
// and the legal-op predicate.
package shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shifts or rotates data by k (0..STEP) positions.
// SRA keeps the MSB, so repeated steps keep filling with the original sign bit.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned STEP = 1,
    localparam int unsigned KW  = $clog2(STEP + 1)
) (
    input  logic [W-1:0]  data,
    input  logic [2:0]    op,
    input  logic [KW-1:0] k,
    output logic [W-1:0]  result
);

    logic [2*W-1:0] dbl;

    always_comb begin
        result = '0;
        dbl    = {data, data};
        case (op)
            OP_SLL: result = data << k;
            OP_SRL: result = data >> k;
            OP_SRA: result = W'($signed(data) >>> k);
            OP_ROR: begin
                dbl    = {data, data} >> k;
                result = dbl[W-1:0];
            end
            OP_ROL: begin
                dbl    = {data, data} << k;
                result = dbl[2*W-1:W];
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator: accepts one request in IDLE, shifts STEP bits
// per cycle in SHIFT and holds the result in DONE until the consumer takes it.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned STEP = 1,
    localparam int unsigned AW  = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_amt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_err,
    output logic          busy
);

    localparam int unsigned LW = $clog2(W);
    localparam int unsigned KW = $clog2(STEP + 1);

    state_t        state, state_n;
    logic [W-1:0]  data_q, data_n;
    logic [2:0]    op_q, op_n;
    logic [AW-1:0] rem_q, rem_n;
    logic [W-1:0]  out_data_n;
    logic          out_err_n;

    logic [AW-1:0] eff_amt;
    logic [AW-1:0] k_amt;
    logic [W-1:0]  step_data;

    // Rotates wrap modulo W; shifts saturate at W.
    always_comb begin
        if (in_op == OP_ROR || in_op == OP_ROL) begin
            eff_amt = AW'(in_amt[LW-1:0]);
        end else begin
            eff_amt = (in_amt > AW'(W)) ? AW'(W) : in_amt;
        end
        k_amt = (rem_q > AW'(STEP)) ? AW'(STEP) : rem_q;
    end

    shift_step #(
        .W    (W),
        .STEP (STEP)
    ) u_step (
        .data   (data_q),
        .op     (op_q),
        .k      (KW'(k_amt)),
        .result (step_data)
    );

    always_comb begin
        state_n    = state;
        data_n     = data_q;
        op_n       = op_q;
        rem_n      = rem_q;
        out_data_n = out_data;
        out_err_n  = out_err;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    data_n = in_data;
                    op_n   = in_op;
                    rem_n  = eff_amt;
                    if (!op_is_legal(in_op)) begin
                        state_n    = ST_DONE;
                        out_data_n = '0;
                        out_err_n  = 1'b1;
                    end else if (eff_amt == '0) begin
                        state_n    = ST_DONE;
                        out_data_n = in_data;
                        out_err_n  = 1'b0;
                    end else begin
                        state_n   = ST_SHIFT;
                        out_err_n = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                data_n = step_data;
                rem_n  = rem_q - k_amt;
                if (rem_q <= AW'(STEP)) begin
                    state_n    = ST_DONE;
                    out_data_n = step_data;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            op_q      <= '0;
            rem_q     <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            data_q    <= data_n;
            op_q      <= op_n;
            rem_q     <= rem_n;
            out_data  <= out_data_n;
            out_err   <= out_err_n;
            out_valid <= (state_n == ST_DONE);
            busy      <= (state_n != ST_IDLE);
            in_ready  <= (state_n == ST_IDLE);
        end
    end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Multi-cycle, parametrised shifter/rotator with valid/ready handshakes on input and output.
- Supports logical left, logical right, sign-filling arithmetic right, rotate right and rotate left.
- Shifts STEP bit positions per cycle under a small FSM, trading latency for area.
- Sits on datapath buses where a full W-wide barrel shifter is too large.

Parameters:
- W, 8: data width; power of two, 4..64.
- STEP, 1: max bit positions shifted per cycle; power of two, 1 <= STEP <= W.
- AW (localparam), $clog2(W)+1: shift-amount width, so an amount of W is representable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- in_data  in  W  operand
- in_op  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101..111 illegal
- in_amt  in  AW  shift amount
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_data  out  W  result
- out_err  out  1  illegal op flag, qualified by out_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, out_valid 0, out_data 0, out_err 0, busy 0, in_ready 1. Internal data, count and op registers are 0.
- Reset is synchronous. Asserting it in any state, including mid-SHIFT or DONE, aborts the operation. No result is emitted and out_valid is 0 on the next cycle.
- in_ready = (state == IDLE). There is no acceptance in SHIFT or DONE, so back-to-back throughput is one request per L+1 cycles.
- Accept occurs on a clock edge where in_valid && in_ready.
  - Capture in_data, in_op and the effective amount E.
  - SLL/SRL/SRA: E = min(in_amt, W), saturating.
  - ROR/ROL: E = in_amt mod W, i.e. the low $clog2(W) bits.
  - Illegal op: out_data = 0 and out_err = 1, go straight to DONE.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE -> DONE on accept when E == 0 or the op is illegal. out_data = operand for E == 0.
  - IDLE -> SHIFT on accept when E > 0.
  - SHIFT: each cycle, apply k = min(STEP, remaining) positions and set remaining -= k. When remaining <= STEP, that same edge moves to DONE.
  - DONE: out_valid = 1 and out_data/out_err are held stable. On out_valid && out_ready, go to IDLE; out_valid drops on the next cycle.
- Latency from the accept edge to out_valid high is L = 1 + ceil(E/STEP) cycles (L = 1 for E = 0 or an illegal op).
- Arithmetic and width rules:
  - SLL fills with 0s from the LSB side.
  - SRL fills with 0s from the MSB side.
  - SRA fills with the captured operand's bit W-1 on every step. The result is the true floor(x/2^E); an amount >= W gives all sign bits.
  - Rotates are lossless.
  - Every intermediate value stays exactly W bits.
- Back-pressure: with out_ready low, DONE persists indefinitely and out_data is held unchanged. Input changes while not in IDLE are ignored.
- in_valid is ignored while in_ready = 0. A requester holding in_valid high is accepted on the first IDLE cycle.

Decomposition:
- Package shifter_pkg holds:
  - the op encoding localparams OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL;
  - the state encoding ST_IDLE, ST_SHIFT, ST_DONE;
  - an op_is_legal function.
- Sub-module shift_step: purely combinational. Inputs are data (W), op (3) and k (0..STEP); output is data shifted or rotated by k. Parameters are W and STEP.
- The top level contains the FSM, the remaining-count register, the handshake logic and one shift_step instance.

Test Plan:
1. W=8, STEP=1, SRA, data 0x90, amt 3, out_ready=1 -> out_data 0xF2, err 0, out_valid 4 cycles after accept, in_ready low throughout.
2. W=8, STEP=1, ROR 0x81 amt 9 -> 0xC0 (E=1, L=2); then ROL 0x81 amt 3 -> 0x0C (L=4); then SLL 0x81 amt 0 -> 0x81 (L=1).
3. W=8, STEP=1, SRL 0xFF amt 12 -> saturates to E=8, out_data 0x00, L=9; SRA 0x80 amt 15 -> 0xFF.
4. W=8, STEP=4, SRA 0x80 amt 7 -> 0xFF with L=3; SLL 0x01 amt 5 -> 0x20 with L=3.
5. Back-pressure: out_ready held low 5 cycles in DONE -> out_data/out_valid stable, in_ready 0, a new in_valid request not accepted. It is accepted the cycle after out_ready rises and the state returns to IDLE.
6. Illegal op 101 with data 0x5A -> out_err 1, out_data 0x00, L=1. Separately, rst pulsed during SHIFT of SLL amt 6 -> next cycle IDLE, out_valid 0, out_data 0, in_ready 1, no stale result later.
